alu_multibyte_seq: RTL and testbench

//  Multi-cycle sequencer that runs one 8-bit ALU over NBYTES-wide operands, one byte per clock.
//  - Chains carry/borrow and shift bits between bytes.
//  - Accumulates a word-level Z flag.
//  - Drives the ALU's SEL/A/B/CIN inputs and reads back its RESULT/C/Z.

---
 rtl/rat_alu_pkg.sv | 29 ++
 rtl/alu_multibyte_seq.sv | 121 ++++++++++++
 tb/tb_alu_multibyte_seq.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/rat_alu_pkg.sv
// rat_alu_pkg: shared RAT ALU op codes, sequencer state type and op classification helper
// Contents:
//   OP_*            4-bit ALU SEL encodings (ADD=0 ... MOV=14, UNUSED=15)
//   seq_state_t     sequencer states IDLE, RUN, DONE
//   is_right_shift  true for ops that walk the bytes from the top down
package rat_alu_pkg;
    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_ADDC   = 4'd1;
    localparam logic [3:0] OP_SUB    = 4'd2;
    localparam logic [3:0] OP_SUBC   = 4'd3;
    localparam logic [3:0] OP_CMP    = 4'd4;
    localparam logic [3:0] OP_AND    = 4'd5;
    localparam logic [3:0] OP_OR     = 4'd6;
    localparam logic [3:0] OP_EXOR   = 4'd7;
    localparam logic [3:0] OP_TEST   = 4'd8;
    localparam logic [3:0] OP_LSL    = 4'd9;
    localparam logic [3:0] OP_LSR    = 4'd10;
    localparam logic [3:0] OP_ROL    = 4'd11;
    localparam logic [3:0] OP_ROR    = 4'd12;
    localparam logic [3:0] OP_ASR    = 4'd13;
    localparam logic [3:0] OP_MOV    = 4'd14;
    localparam logic [3:0] OP_UNUSED = 4'd15;

    typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

    function automatic logic is_right_shift(input logic [3:0] op);
        return op inside {OP_LSR, OP_ROR, OP_ASR};
    endfunction
endpackage

// File: rtl/alu_multibyte_seq.sv
// alu_multibyte_seq: runs an external 8-bit RAT ALU over NBYTES-wide operands, one byte per clock
// Ports:
//   clk, rst                     clock (rising edge), asynchronous active-high reset
//   start, op, a_in, b_in, cin_in  request and operands, sampled only in IDLE
//   busy, done, err              status; done/err are one-cycle pulses
//   result, c, z                 registered word result and flags
//   alu_sel, alu_a, alu_b, alu_cin  drive the ALU (zero outside RUN)
//   alu_result, alu_c, alu_z     combinational ALU outputs
module alu_multibyte_seq
    import rat_alu_pkg::*;
#(
    parameter int NBYTES = 2,
    localparam int W = 8 * NBYTES,
    localparam int IW = $clog2(NBYTES)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic         cin_in,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] result,
    output logic         c,
    output logic         z,
    output logic [3:0]   alu_sel,
    output logic [7:0]   alu_a,
    output logic [7:0]   alu_b,
    output logic         alu_cin,
    input  logic [7:0]   alu_result,
    input  logic         alu_c,
    input  logic         alu_z
);
    seq_state_t   state, state_nx;
    logic [W-1:0] a_r, b_r, temp, temp_nx;
    logic [3:0]   op_r;
    logic [IW-1:0] idx;
    logic         cy, zacc, right, first, last, accept;

    assign accept = state == IDLE && start;
    assign right  = is_right_shift(op_r);
    assign first  = right ? idx == IW'(NBYTES - 1) : idx == '0;
    assign last   = right ? idx == '0 : idx == IW'(NBYTES - 1);
    assign busy   = state != IDLE;
    assign done   = state == DONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE ? (start ? (op == OP_UNUSED ? DONE : RUN) : IDLE)
                 : state == RUN  ? (last ? DONE : RUN)
                 : IDLE;
    end

    // Byte-level SEL: the first byte of a chained op uses the carry-less form,
    // rotates reuse the shift SELs with the wrap-around bit preloaded into cy.
    always_comb begin
        alu_sel = '0;
        alu_a   = '0;
        alu_b   = '0;
        alu_cin = 1'b0;
        temp_nx = temp;
        temp_nx[{idx, 3'b000} +: 8] = alu_result;
        if (state == RUN) begin
            alu_a   = a_r[{idx, 3'b000} +: 8];
            alu_b   = b_r[{idx, 3'b000} +: 8];
            alu_cin = cy;
            case (op_r)
                OP_ADD:         alu_sel = first ? OP_ADD : OP_ADDC;
                OP_SUB, OP_CMP: alu_sel = first ? OP_SUB : OP_SUBC;
                OP_ROL:         alu_sel = OP_LSL;
                OP_ROR:         alu_sel = OP_LSR;
                OP_ASR:         alu_sel = first ? OP_ASR : OP_LSR;
                default:        alu_sel = op_r;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            op_r   <= '0;
            temp   <= '0;
            idx    <= '0;
            cy     <= 1'b0;
            zacc   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
            c      <= 1'b0;
            z      <= 1'b0;
        end else begin
            err <= accept && op == OP_UNUSED;
            if (accept && op != OP_UNUSED) begin
                a_r  <= a_in;
                b_r  <= b_in;
                op_r <= op;
                idx  <= is_right_shift(op) ? IW'(NBYTES - 1) : '0;
                zacc <= 1'b1;
                cy   <= op == OP_ROL ? a_in[W-1] : op == OP_ROR ? a_in[0] : cin_in;
            end
            if (state == RUN) begin
                temp <= temp_nx;
                cy   <= alu_c;
                zacc <= zacc & alu_z;
                idx  <= right ? idx - IW'(1) : idx + IW'(1);
                if (last) begin
                    c <= alu_c;
                    z <= zacc & alu_z;
                    if (!(op_r inside {OP_CMP, OP_TEST})) result <= temp_nx;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_multibyte_seq.sv
// tb_alu_multibyte_seq: self-checking bench with a byte ALU model and a word-level reference
module tb_alu_multibyte_seq;
    import rat_alu_pkg::*;
    localparam int NB = 2;
    localparam int W = 8 * NB;

    logic         clk = 1'b0;
    logic         rst, start, cin_in;
    logic [3:0]   op;
    logic [W-1:0] a_in, b_in, result;
    logic         busy, done, err, c, z;
    logic [3:0]   alu_sel;
    logic [7:0]   alu_a, alu_b, alu_result;
    logic         alu_cin, alu_c, alu_z;
    logic [8:0]   t;

    int pass = 0, total = 0;
    logic [W-1:0] exp_r = '0;
    logic         exp_c = 1'b0, exp_z = 1'b0;
    int           lat;
    logic         err_seen;
    logic [8:0]   busy_mask;
    logic [3:0]   sels [1:8];
    logic [7:0]   as_ [1:8];

    always #5 clk = ~clk;

    alu_multibyte_seq #(.NBYTES(NB)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
        .busy(busy), .done(done), .err(err), .result(result), .c(c), .z(z),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_c(alu_c), .alu_z(alu_z)
    );

    // The external 8-bit RAT ALU
    always_comb begin
        case (alu_sel)
            OP_ADD:  t = {1'b0, alu_a} + {1'b0, alu_b};
            OP_ADDC: t = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_cin};
            OP_SUB:  t = {1'b0, alu_a} - {1'b0, alu_b};
            OP_SUBC: t = {1'b0, alu_a} - {1'b0, alu_b} - {8'b0, alu_cin};
            OP_CMP:  t = {1'b0, alu_a} - {1'b0, alu_b};
            OP_AND:  t = {1'b0, alu_a & alu_b};
            OP_OR:   t = {1'b0, alu_a | alu_b};
            OP_EXOR: t = {1'b0, alu_a ^ alu_b};
            OP_TEST: t = {1'b0, alu_a & alu_b};
            OP_LSL:  t = {alu_a, alu_cin};
            OP_LSR:  t = {alu_a[0], alu_cin, alu_a[7:1]};
            OP_ROL:  t = {alu_a, alu_a[7]};
            OP_ROR:  t = {alu_a[0], alu_a[0], alu_a[7:1]};
            OP_ASR:  t = {alu_a[0], alu_a[7], alu_a[7:1]};
            OP_MOV:  t = {1'b0, alu_b};
            default: t = '0;
        endcase
    end
    assign alu_result = t[7:0];
    assign alu_c = t[8];
    assign alu_z = t[7:0] == 8'h00;

    // Word-level reference: {carry, result} of the whole-word operation
    function automatic logic [W:0] ref_op(input logic [3:0] o, input logic [W-1:0] a, b, input logic ci);
        case (o)
            OP_ADD:          return {1'b0, a} + {1'b0, b};
            OP_ADDC:         return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
            OP_SUB, OP_CMP:  return {1'b0, a} - {1'b0, b};
            OP_SUBC:         return {1'b0, a} - {1'b0, b} - {{W{1'b0}}, ci};
            OP_AND, OP_TEST: return {1'b0, a & b};
            OP_OR:           return {1'b0, a | b};
            OP_EXOR:         return {1'b0, a ^ b};
            OP_LSL:          return {a, ci};
            OP_LSR:          return {a[0], ci, a[W-1:1]};
            OP_ROL:          return {a[W-1], a[W-2:0], a[W-1]};
            OP_ROR:          return {a[0], a[0], a[W-1:1]};
            OP_ASR:          return {a[0], a[W-1], a[W-1:1]};
            OP_MOV:          return {1'b0, b};
            default:         return '0;
        endcase
    endfunction

    // Issue one request, optionally re-pulse start while busy, and wait (bounded) for done
    task automatic run(input logic [3:0] o, input logic [W-1:0] a, b, input logic ci, input bit poke);
        logic [W:0] r;
        @(negedge clk);
        start = 1'b1; op = o; a_in = a; b_in = b; cin_in = ci;
        @(posedge clk);
        #1;
        start = 1'b0; op = 4'($urandom); a_in = W'($urandom); b_in = W'($urandom); cin_in = 1'($urandom);
        lat = 99; err_seen = 1'b0; busy_mask = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            busy_mask[k] = busy;
            sels[k] = alu_sel;
            as_[k] = alu_a;
            if (poke) start = (k == 1);
            if (done) begin
                lat = k;
                err_seen = err;
                break;
            end
        end
        start = 1'b0;
        if (o != OP_UNUSED) begin
            r = ref_op(o, a, b, ci);
            exp_c = r[W];
            exp_z = r[W-1:0] == '0;
            if (!(o inside {OP_CMP, OP_TEST})) exp_r = r[W-1:0];
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; op = '0; a_in = '0; b_in = '0; cin_in = 1'b0;
        repeat (2) @(negedge clk);
        total++; if ({result, c, z, busy, done, err} !== '0) $display("FAIL reset_outputs got=%h want=0", {result, c, z, busy, done, err}); else pass++;
        total++; if ({alu_sel, alu_a, alu_b, alu_cin} !== '0) $display("FAIL reset_alu_ports got=%h want=0", {alu_sel, alu_a, alu_b, alu_cin}); else pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add;
        run(OP_ADD, 16'h00FF, 16'h0001, 1'b0, 0);
        total++; if (result !== 16'h0100) $display("FAIL add_result got=%h want=0100", result); else pass++;
        total++; if ({c, z} !== 2'b00) $display("FAIL add_flags got=%b want=00", {c, z}); else pass++;
        total++; if (lat !== 3) $display("FAIL add_latency got=%0d want=3", lat); else pass++;
        total++; if (busy_mask !== 9'b0_0000_1110) $display("FAIL add_busy got=%b want=000001110", busy_mask); else pass++;
        @(negedge clk);
        total++; if ({busy, done} !== 2'b00) $display("FAIL add_after got=%b want=00", {busy, done}); else pass++;
    endtask

    task automatic test_sub_cmp;
        run(OP_SUB, 16'h0000, 16'h0001, 1'b0, 0);
        total++; if ({c, result} !== {1'b1, 16'hFFFF}) $display("FAIL sub got=%h want=1ffff", {c, result}); else pass++;
        run(OP_CMP, 16'h1234, 16'h1234, 1'b0, 0);
        total++; if ({z, c, result} !== {2'b10, 16'hFFFF}) $display("FAIL cmp got=%h want=2ffff", {z, c, result}); else pass++;
    endtask

    task automatic test_shifts;
        run(OP_ASR, 16'h8001, 16'h0000, 1'b0, 0);
        total++; if ({c, result} !== {1'b1, 16'hC000}) $display("FAIL asr got=%h want=1c000", {c, result}); else pass++;
        total++; if ({sels[1], sels[2]} !== {OP_ASR, OP_LSR}) $display("FAIL asr_sel got=%h want=da", {sels[1], sels[2]}); else pass++;
        run(OP_ROL, 16'h8000, 16'h0000, 1'b0, 0);
        total++; if ({c, result} !== {1'b1, 16'h0001}) $display("FAIL rol got=%h want=10001", {c, result}); else pass++;
    endtask

    task automatic test_lsr;
        run(OP_LSR, 16'h0100, 16'h0000, 1'b1, 0);
        total++; if ({c, result} !== {1'b0, 16'h8080}) $display("FAIL lsr got=%h want=08080", {c, result}); else pass++;
        total++; if ({sels[1], sels[2]} !== 8'hAA) $display("FAIL lsr_sel got=%h want=aa", {sels[1], sels[2]}); else pass++;
        total++; if ({as_[1], as_[2]} !== 16'h0100) $display("FAIL lsr_order got=%h want=0100", {as_[1], as_[2]}); else pass++;
    endtask

    task automatic test_err_busy;
        int busy_cnt;
        run(OP_UNUSED, 16'hFFFF, 16'hFFFF, 1'b1, 0);
        total++; if (lat !== 1) $display("FAIL err_latency got=%0d want=1", lat); else pass++;
        total++; if (err_seen !== 1'b1) $display("FAIL err_pulse got=%b want=1", err_seen); else pass++;
        total++; if ({result, c, z} !== {16'h8080, 2'b00}) $display("FAIL err_hold got=%h want=%h", {result, c, z}, {16'h8080, 2'b00}); else pass++;
        @(negedge clk);
        total++; if ({err, done} !== 2'b00) $display("FAIL err_clear got=%b want=00", {err, done}); else pass++;
        run(OP_ADD, 16'h1111, 16'h2222, 1'b0, 1);
        total++; if ({lat, result} !== {32'd3, 16'h3333}) $display("FAIL busy_ignore got=%0d/%h want=3/3333", lat, result); else pass++;
        busy_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        total++; if (busy_cnt !== 0) $display("FAIL no_queue got=%0d want=0", busy_cnt); else pass++;
    endtask

    task automatic test_abort;
        @(negedge clk);
        start = 1'b1; op = OP_ADD; a_in = 16'h4444; b_in = 16'h1111; cin_in = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b1) $display("FAIL abort_running got=%b want=1", busy); else pass++;
        rst = 1'b1;
        #1;
        total++; if ({result, c, z, busy, done, err} !== '0) $display("FAIL abort_outputs got=%h want=0", {result, c, z, busy, done, err}); else pass++;
        total++; if ({alu_sel, alu_a, alu_b, alu_cin} !== '0) $display("FAIL abort_alu got=%h want=0", {alu_sel, alu_a, alu_b, alu_cin}); else pass++;
        @(negedge clk);
        rst = 1'b0;
        exp_r = '0; exp_c = 1'b0; exp_z = 1'b0;
        run(OP_ADD, 16'h0001, 16'h0001, 1'b0, 0);
        total++; if ({c, z, result} !== {2'b00, 16'h0002}) $display("FAIL abort_next got=%h want=00002", {c, z, result}); else pass++;
    endtask

    task automatic test_random;
        logic [3:0] o;
        for (int i = 0; i < 60; i++) begin
            o = 4'($urandom_range(0, 15));
            run(o, W'($urandom), W'($urandom), 1'($urandom), 0);
            total++; if (lat !== (o == OP_UNUSED ? 1 : NB + 1)) $display("FAIL rnd_lat op=%0d got=%0d", o, lat); else pass++;
            total++; if (err_seen !== (o == OP_UNUSED)) $display("FAIL rnd_err op=%0d got=%b", o, err_seen); else pass++;
            total++; if ({result, c, z} !== {exp_r, exp_c, exp_z}) $display("FAIL rnd_word op=%0d got=%h want=%h", o, {result, c, z}, {exp_r, exp_c, exp_z}); else pass++;
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub_cmp;
        test_shifts;
        test_lsr;
        test_err_busy;
        test_abort;
        test_random;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
